instr_sequencer: RTL
====================

// Module: instr_sequencer
// PURPOSE
//  Control-side initiator for the combinational sign-magnitude ALU: accepts one instruction per handshake, decodes it,
//  reads an internal 8x16 register file, and drives the ALU opcode and operands. It captures the ALU result and writes
//  back to the destination register. It also executes the non-ALU ops LOAD, CLEAR and DISPLAY itself.
//  Sits between the instruction source (keypad/ROM front end) and the ALU/display path.
// PARAMETERS
//  DATA_W    16  register/ALU data width (sign-magnitude, bit DATA_W-1 = sign)
//  NUM_REGS   8  register-file depth; register index width = $clog2(NUM_REGS) = 3
//  IMM_W      7  immediate width, sign-magnitude (bit IMM_W-1 = sign)
// PORTS
//  clk            in   1   system clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  instr_valid    in   1   instruction present
//  instr_ready    out  1   sequencer can accept (high only in IDLE)
//  instr          in   17  [16:14] opcode, [13:11] rd, [10:8] rs1, [7:5] rs2, [6:0] imm (rs2/imm overlap; use per opcode)
//  alu_opcode     out  3   to ALU opcode
//  alu_reg_a      out  16  to ALU register_A
//  alu_reg_b      out  16  to ALU register_B
//  alu_result     in   16  from ALU result (combinational)
//  display_valid  out  1   display_data valid
//  display_ready  in   1   display sink accepts
//  display_data   out  16  value shown (sign-magnitude)
//  busy           out  1   ~instr_ready
//  done           out  1   one-cycle pulse per retired instruction
//  retired_count  out  16  retired instructions (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all registers=0; done=0; display_valid=0; display_data=0; alu_* =0; count=0.
//  Opcodes: LOAD=0 ADD=1 ADDI=2 SUB=3 SUBI=4 MUL=5 CLEAR=6 DISPLAY=7.
//  Accept on instr_valid&instr_ready edge; instr latched; IDLE->DECODE.
//  DECODE: latch opA=R[rs1], opB=R[rs2] (ADD/SUB/MUL) or imm_ext (ADDI/SUBI). Then:
//   LOAD->WB; CLEAR->CLR; DISPLAY->DISP; ALU ops->EXEC.
//  imm_ext = {imm[6], 9'b0, imm[5:0]} (sign kept, magnitude zero-extended; imm 7'b1000000 -> 16'h8000).
//  EXEC (1 cycle): alu_opcode=op, alu_reg_a=opA, alu_reg_b=opB; alu_result latched at end -> WB.
//   Outside EXEC alu_opcode=LOAD(0) and operands=0, so the ALU result stays 0.
//  WB (1 cycle): R[rd] <= LOAD ? imm_ext : latched result; ->IDLE, done=1 next cycle.
//  ALU op: accept-to-next-accept = 4 cycles; LOAD = 3 cycles.
//  CLR: 3-bit counter writes R[0..NUM_REGS-1]=0, one per cycle; after last ->IDLE with done.
//  DISP: display_data=R[rs1] registered on entry; display_valid held until display_ready. Data stays stable meanwhile.
//   On display_valid&display_ready: valid drops, ->IDLE, done.
//  rd==rs1/rs2 is legal: reads occur in DECODE, before WB.
//  instr_valid ignored while busy; no queuing. instr must be held only until the accept edge.
//  Reset mid-operation: immediate IDLE; the pending write is lost; display_valid drops; regfile is zeroed.
//  No overflow handling: ALU result is written verbatim.
// CONFIGURATION
//  RETIRE_CNT_EN defined: retired_count increments (wraps 16'hFFFF->0) on every done pulse.
//  RETIRE_CNT_EN undefined: retired_count tied to 16'd0, counter not instantiated.
// STRUCTURE
//  Package cpu_pkg: opcode localparams (shared with ALU), state encoding,
//   instruction field positions, imm_ext function.
//  Sub-module seq_regfile: NUM_REGS x DATA_W, 2 async read ports, 1 sync write port, async clear on rst_n.
// TESTING
//  1 Reset: instr_ready=1, busy=0, done=0, display_valid=0, retired_count=0; DISPLAY each Rn -> 16'h0000.
//  2 LOAD R1,imm=7'b1000101 -> R1=16'h8005. DISPLAY R1 with display_ready low 3 cycles -> data 16'h8005 stable,
//    valid held; ready high -> done pulse.
//  3 LOAD R2,+3; ADD R3,R1,R2 -> EXEC cycle alu_opcode=1, A=16'h8005, B=16'h0003; R3=16'h8002 (real ALU in bench);
//    4 cycles accept-to-accept.
//  4 ADDI R4,R2,imm=7'b0000100 -> B=16'h0004, R4=16'h0007; SUBI R4,R4,7'b0000111 -> R4=16'h0000;
//    MUL R5,R1,R1 -> 16'h0019.
//  5 CLEAR -> busy for 1+NUM_REGS cycles after accept, one done pulse; all regs then read 16'h0000;
//    instr_valid during busy ignored.
//  6 rst_n low mid-CLR and mid-DISP wait -> same-cycle IDLE, display_valid=0, no done.
//    With RETIRE_CNT_EN, count = done pulses (check 16'hFFFF wrap by force).

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes shared with the ALU, sequencer state encoding, instruction
// field positions and the sign-magnitude immediate extender.
package cpu_pkg;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int REG_W    = $clog2(NUM_REGS);
    localparam int IMM_W    = 7;
    localparam int INSTR_W  = 17;
    localparam int OPC_LSB  = 14;
    localparam int RD_LSB   = 11;
    localparam int RS1_LSB  = 8;
    localparam int RS2_LSB  = 5;
    localparam logic [2:0] OP_LOAD    = 3'd0;
    localparam logic [2:0] OP_ADD     = 3'd1;
    localparam logic [2:0] OP_ADDI    = 3'd2;
    localparam logic [2:0] OP_SUB     = 3'd3;
    localparam logic [2:0] OP_SUBI    = 3'd4;
    localparam logic [2:0] OP_MUL     = 3'd5;
    localparam logic [2:0] OP_CLEAR   = 3'd6;
    localparam logic [2:0] OP_DISPLAY = 3'd7;
    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_WB, S_CLR, S_DISP} state_t;
    // Sign bit kept in the MSB, magnitude zero-extended.
    function automatic logic [DATA_W-1:0] imm_ext(input logic [IMM_W-1:0] imm);
        return {imm[IMM_W-1], {(DATA_W-IMM_W){1'b0}}, imm[IMM_W-2:0]};
    endfunction
endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: instruction handshake, ALU drive/return and display handshake.
interface instr_sequencer_if;
    import cpu_pkg::*;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [2:0]         alu_opcode;
    logic [DATA_W-1:0]  alu_reg_a;
    logic [DATA_W-1:0]  alu_reg_b;
    logic [DATA_W-1:0]  alu_result;
    logic               display_valid;
    logic               display_ready;
    logic [DATA_W-1:0]  display_data;
    modport master (
        input  instr_valid, instr, alu_result, display_ready,
        output instr_ready, alu_opcode, alu_reg_a, alu_reg_b, display_valid, display_data
    );
    modport slave (
        output instr_valid, instr, alu_result, display_ready,
        input  instr_ready, alu_opcode, alu_reg_a, alu_reg_b, display_valid, display_data
    );
endinterface

// File: rtl/seq_regfile.sv
// seq_regfile: NUM_REGS x DATA_W register file, two async read ports, one sync write port.
module seq_regfile
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_W-1:0]  raddr1,
    input  logic [REG_W-1:0]  raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);
    logic [DATA_W-1:0] mem [NUM_REGS];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        else if (we)
            mem[waddr] <= wdata;
    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: decodes instructions, drives the sign-magnitude ALU and runs LOAD/CLEAR/DISPLAY.
// Optional retired-instruction counter enabled by defining RETIRE_CNT_EN.
module instr_sequencer
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    instr_sequencer_if.master  bus,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  retired_count
);
    state_t             state, state_nx;
    logic [INSTR_W-1:0] ir;
    logic [DATA_W-1:0]  op_a, op_b, res, rd1, rd2, wdata;
    logic [REG_W-1:0]   cnt, waddr, rd, rs1, rs2;
    logic [IMM_W-1:0]   imm;
    logic [2:0]         opc;
    logic               we;
    assign opc = ir[OPC_LSB +: 3];
    assign rd  = ir[RD_LSB +: REG_W];
    assign rs1 = ir[RS1_LSB +: REG_W];
    assign rs2 = ir[RS2_LSB +: REG_W];
    assign imm = ir[IMM_W-1:0];
    seq_regfile u_regfile (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(rs1), .raddr2(rs2), .rdata1(rd1), .rdata2(rd2)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (bus.instr_valid) state_nx = S_DECODE;
            S_DECODE: state_nx = opc == OP_LOAD ? S_WB : opc == OP_CLEAR ? S_CLR :
                                 opc == OP_DISPLAY ? S_DISP : S_EXEC;
            S_EXEC:   state_nx = S_WB;
            S_WB:     state_nx = S_IDLE;
            S_CLR:    if (cnt == REG_W'(NUM_REGS-1)) state_nx = S_IDLE;
            S_DISP:   if (bus.display_ready) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end
    // ALU inputs are parked at LOAD/0 outside EXEC so its result stays 0.
    always_comb begin
        bus.instr_ready = state == S_IDLE;
        busy            = state != S_IDLE;
        bus.alu_opcode  = state == S_EXEC ? opc : OP_LOAD;
        bus.alu_reg_a   = state == S_EXEC ? op_a : '0;
        bus.alu_reg_b   = state == S_EXEC ? op_b : '0;
        we              = state == S_WB || state == S_CLR;
        waddr           = state == S_CLR ? cnt : rd;
        wdata           = state == S_CLR ? '0 : opc == OP_LOAD ? imm_ext(imm) : res;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir                <= '0;
            op_a              <= '0;
            op_b              <= '0;
            res               <= '0;
            cnt               <= '0;
            done              <= 1'b0;
            bus.display_valid <= 1'b0;
            bus.display_data  <= '0;
        end else begin
            done <= state != S_IDLE && state_nx == S_IDLE;
            if (state == S_IDLE && bus.instr_valid) ir <= bus.instr;
            if (state == S_DECODE) begin
                op_a <= rd1;
                op_b <= (opc == OP_ADDI || opc == OP_SUBI) ? imm_ext(imm) : rd2;
                cnt  <= '0;
                if (opc == OP_DISPLAY) begin
                    bus.display_data  <= rd1;
                    bus.display_valid <= 1'b1;
                end
            end
            if (state == S_EXEC) res <= bus.alu_result;
            if (state == S_CLR) cnt <= cnt + 1'b1;
            if (state == S_DISP && bus.display_ready) bus.display_valid <= 1'b0;
        end
    end
`ifdef RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)    retired_count <= '0;
        else if (done) retired_count <= retired_count + 1'b1;
`else
    assign retired_count = '0;
`endif
endmodule
